// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART <-> ALU sequencing controller:
// one-hot state codes and default widths and timeout.
package alu_uart_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_OP_WIDTH       = 6;
   localparam int DEF_TIMEOUT_CYCLES = 1000000;

   localparam logic [5:0] IDLE_CODE    = 6'b000001;
   localparam logic [5:0] WAIT_B_CODE  = 6'b000010;
   localparam logic [5:0] WAIT_OP_CODE = 6'b000100;
   localparam logic [5:0] EXEC_CODE    = 6'b001000;
   localparam logic [5:0] SEND_CODE    = 6'b010000;
   localparam logic [5:0] WAIT_TX_CODE = 6'b100000;

   typedef enum logic [5:0] {
      IDLE    = IDLE_CODE,
      WAIT_B  = WAIT_B_CODE,
      WAIT_OP = WAIT_OP_CODE,
      EXEC    = EXEC_CODE,
      SEND    = SEND_CODE,
      WAIT_TX = WAIT_TX_CODE
   } state_t;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte timeout counter: counts while enabled, clears on request,
// flags expiry when the count reaches TIMEOUT_CYCLES-1.
import alu_uart_pkg::*;

module rx_timeout_counter #(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Count register; clear has priority over counting.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= {CW{1'b0}};
      end else if (clear) begin
         count <= {CW{1'b0}};
      end else if (count_en) begin
         count <= count + CW'(1);
      end else begin
         count <= count;
      end
   end

   assign expire = count_en && (count == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer gathering A, B and opcode bytes from the UART receiver, sampling
// the ALU result and launching the transmitter. Optional inter-byte timeout
// is enabled by defining ALU_UART_CTRL_TIMEOUT_EN.
import alu_uart_pkg::*;

module alu_uart_ctrl #(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int OP_WIDTH       = DEF_OP_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_rx_done,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic                  i_tx_done,
   output logic [DATA_WIDTH-1:0] o_alu_a,
   output logic [DATA_WIDTH-1:0] o_alu_b,
   output logic [OP_WIDTH-1:0]   o_alu_op,
   output logic                  o_tx_start,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_busy,
   output logic                  o_timeout
);

   state_t state;
   state_t state_next;
   logic   collecting;
   logic   expire;

   assign collecting = (state == WAIT_B) || (state == WAIT_OP);

`ifdef ALU_UART_CTRL_TIMEOUT_EN
   logic timed_out;

   rx_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (i_clock),
      .reset   (i_reset),
      .clear   (!collecting || i_rx_done),
      .count_en(collecting),
      .expire  (expire)
   );

   // A byte arriving in the expiry cycle wins over the timeout.
   assign timed_out = collecting && expire && !i_rx_done;

   // One-cycle pulse when a partial frame is abandoned.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= timed_out;
      end
   end
`else
   assign expire    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; illegal encodings recover to IDLE.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE: begin
            if (i_rx_done) state_next = WAIT_B;
            else           state_next = IDLE;
         end
         WAIT_B: begin
            if (i_rx_done)   state_next = WAIT_OP;
            else if (expire) state_next = IDLE;
            else             state_next = WAIT_B;
         end
         WAIT_OP: begin
            if (i_rx_done)   state_next = EXEC;
            else if (expire) state_next = IDLE;
            else             state_next = WAIT_OP;
         end
         EXEC:    state_next = SEND;
         SEND:    state_next = WAIT_TX;
         WAIT_TX: begin
            if (i_tx_done) state_next = IDLE;
            else           state_next = WAIT_TX;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers and registered status decodes.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_alu_a    <= {DATA_WIDTH{1'b0}};
         o_alu_b    <= {DATA_WIDTH{1'b0}};
         o_alu_op   <= {OP_WIDTH{1'b0}};
         o_tx_data  <= {DATA_WIDTH{1'b0}};
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (i_rx_done) o_alu_a  <= i_rx_data;
            WAIT_B:  if (i_rx_done) o_alu_b  <= i_rx_data;
            WAIT_OP: if (i_rx_done) o_alu_op <= i_rx_data[OP_WIDTH-1:0];
            EXEC:    o_tx_data <= i_alu_result;
            default: begin
            end
         endcase
         o_tx_start <= (state_next == SEND);
         o_busy     <= (state_next != IDLE);
      end
   end

endmodule
